// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared constants for the pipeline hazard/stall controller.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package pipe_stall_ctrl_pkg;

  // IF PC mux select codes
  localparam logic [1:0] PC_SEL_SEQ  = 2'b00;  // PC+4
  localparam logic [1:0] PC_SEL_ID   = 2'b01;  // branch/jump target from ID
  localparam logic [1:0] PC_SEL_HOLD = 2'b10;  // re-fetch current PC

  // Hard-wired zero register never produces a hazard
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MDU_BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/mdu_busy_timer.sv
// MDU occupancy timer: loads on issue, flags busy for MDU_LAT cycles.
// Latency: busy rises the cycle after issue, stays high exactly MDU_LAT cycles.
// Backpressure: none; caller must not issue while busy (ignored if it does).
// Ports: clk, rst (async, active-high), issue (MDU op leaves ID), busy (MDU occupied).
module mdu_busy_timer
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int MDU_LAT = 32,
  parameter int CNT_W   = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic issue,
  output logic busy
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // cnt holds the number of busy cycles remaining after the current one,
  // so loading MDU_LAT-1 yields MDU_LAT busy cycles in total.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN: begin
        if (issue) begin
          state_d = ST_MDU_BUSY;
          cnt_d   = CNT_W'(MDU_LAT - 1);
        end
      end
      ST_MDU_BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  assign busy = (state_q == ST_MDU_BUSY);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Hazard/stall controller beside ID: drives IF PC select, ID hold and ID/EX bubble.
// Latency: all control outputs are combinational from inputs and MDU state (same cycle).
// Backpressure: stall holds IF PC and the ID instruction and bubbles EX until hazards clear.
// Ports: ID operand/class info, ID redirect, EX load/write info in; if_pc_sel,
//   id_inst_stop, ex_bubble, mdu_busy out. Optional build macro PIPE_STALL_PERF_EN
//   adds stall_cycles and redirect_cnt performance counters.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int MDU_LAT = 32,
  parameter int CNT_W   = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic        id_is_mdu,
  input  logic        id_reads_hilo,
  input  logic        id_redirect,
  input  logic        ex_is_load,
  input  logic        ex_rf_wena,
  input  logic [4:0]  ex_rf_waddr,
  output logic [1:0]  if_pc_sel,
  output logic        id_inst_stop,
  output logic        ex_bubble,
  output logic        mdu_busy
`ifdef PIPE_STALL_PERF_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] redirect_cnt
`endif
);

  logic busy;
  logic rs_match, rt_match;
  logic lu_haz, mdu_haz, stall, issue;

  assign rs_match = id_uses_rs && (id_rs == ex_rf_waddr);
  assign rt_match = id_uses_rt && (id_rt == ex_rf_waddr);
  assign lu_haz   = ex_is_load && ex_rf_wena && (ex_rf_waddr != REG_ZERO) && (rs_match || rt_match);
  assign mdu_haz  = busy && (id_is_mdu || id_reads_hilo);
  assign stall    = lu_haz || mdu_haz;
  assign issue    = id_is_mdu && !stall;

  mdu_busy_timer #(
    .MDU_LAT (MDU_LAT),
    .CNT_W   (CNT_W)
  ) u_mdu_busy_timer (
    .clk   (clk),
    .rst   (rst),
    .issue (issue),
    .busy  (busy)
  );

  // Stall wins over redirect: the held instruction re-evaluates its
  // branch next cycle. Outputs are forced quiet while reset is asserted.
  always_comb begin
    if_pc_sel    = PC_SEL_SEQ;
    id_inst_stop = 1'b0;
    ex_bubble    = 1'b0;
    if (!rst) begin
      if (stall) begin
        if_pc_sel    = PC_SEL_HOLD;
        id_inst_stop = 1'b1;
        ex_bubble    = 1'b1;
      end else if (id_redirect) begin
        if_pc_sel = PC_SEL_ID;
      end
    end
  end

  assign mdu_busy = busy && !rst;

`ifdef PIPE_STALL_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
      redirect_cnt <= '0;
    end else begin
      if (stall)                    stall_cycles <= stall_cycles + 32'd1;
      if (if_pc_sel == PC_SEL_ID)   redirect_cnt <= redirect_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: directed scenarios plus random traffic.
// Latency: outputs sampled on the falling edge, reference model advanced on the rising edge.
// Backpressure: n/a.
module tb_pipe_stall_ctrl;

  localparam int MDU_LAT = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs, id_rt, ex_rf_waddr;
  logic        id_uses_rs, id_uses_rt, id_is_mdu, id_reads_hilo, id_redirect;
  logic        ex_is_load, ex_rf_wena;
  logic [1:0]  if_pc_sel;
  logic        id_inst_stop, ex_bubble, mdu_busy;
`ifdef PIPE_STALL_PERF_EN
  logic [31:0] stall_cycles, redirect_cnt;
`endif

  pipe_stall_ctrl #(.MDU_LAT(MDU_LAT), .CNT_W(7)) dut (
    .clk           (clk),
    .rst           (rst),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_uses_rs    (id_uses_rs),
    .id_uses_rt    (id_uses_rt),
    .id_is_mdu     (id_is_mdu),
    .id_reads_hilo (id_reads_hilo),
    .id_redirect   (id_redirect),
    .ex_is_load    (ex_is_load),
    .ex_rf_wena    (ex_rf_wena),
    .ex_rf_waddr   (ex_rf_waddr),
    .if_pc_sel     (if_pc_sel),
    .id_inst_stop  (id_inst_stop),
    .ex_bubble     (ex_bubble),
    .mdu_busy      (mdu_busy)
`ifdef PIPE_STALL_PERF_EN
    ,
    .stall_cycles  (stall_cycles),
    .redirect_cnt  (redirect_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference model state: busy cycles still to come, and event tallies.
  int busy_left;
  int exp_stalls;
  int exp_redirs;
  int n_checks;
  int n_pass;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic set_idle();
    id_rs = 5'd0; id_rt = 5'd0; ex_rf_waddr = 5'd0;
    id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_is_mdu = 1'b0;
    id_reads_hilo = 1'b0; id_redirect = 1'b0;
    ex_is_load = 1'b0; ex_rf_wena = 1'b0;
  endtask

  // Check one cycle against the model, then clock it. Entered just after a rising edge.
  task automatic cycle_check(output logic [1:0] sel_seen);
    logic lu, mh, st;
    logic [1:0] esel;
    @(negedge clk);
    lu = ex_is_load && ex_rf_wena && (ex_rf_waddr != 5'd0) &&
         ((id_uses_rs && id_rs == ex_rf_waddr) || (id_uses_rt && id_rt == ex_rf_waddr));
    mh = (busy_left > 0) && (id_is_mdu || id_reads_hilo);
    st = lu || mh;
    esel = st ? 2'b10 : (id_redirect ? 2'b01 : 2'b00);
    sel_seen = if_pc_sel;
    check("if_pc_sel", {30'd0, if_pc_sel}, {30'd0, esel});
    check("id_inst_stop", {31'd0, id_inst_stop}, {31'd0, st});
    check("ex_bubble", {31'd0, ex_bubble}, {31'd0, st});
    check("mdu_busy", {31'd0, mdu_busy}, {31'd0, busy_left > 0});
`ifdef PIPE_STALL_PERF_EN
    check("stall_cycles", stall_cycles, exp_stalls);
    check("redirect_cnt", redirect_cnt, exp_redirs);
`endif
    @(posedge clk);
    if (busy_left > 0) busy_left--;
    else if (id_is_mdu && !st) busy_left = MDU_LAT;
    if (st) exp_stalls++;
    if (esel == 2'b01) exp_redirs++;
    #1;
  endtask

  // Assert reset with hazard-looking inputs; outputs must go quiet at once.
  task automatic do_reset();
    set_idle();
    ex_is_load = 1'b1; ex_rf_wena = 1'b1; ex_rf_waddr = 5'd3;
    id_rs = 5'd3; id_uses_rs = 1'b1; id_redirect = 1'b1;
    rst = 1'b1;
    #1;
    busy_left = 0; exp_stalls = 0; exp_redirs = 0;
    check("rst_pc_sel", {30'd0, if_pc_sel}, 32'd0);
    check("rst_stop", {31'd0, id_inst_stop}, 32'd0);
    check("rst_bubble", {31'd0, ex_bubble}, 32'd0);
    check("rst_mdu_busy", {31'd0, mdu_busy}, 32'd0);
`ifdef PIPE_STALL_PERF_EN
    check("rst_stall_cycles", stall_cycles, 32'd0);
    check("rst_redirect_cnt", redirect_cnt, 32'd0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    set_idle();
  endtask

  logic [1:0] sel;
  int         stalls;

  initial begin
    n_checks = 0; n_pass = 0;
    busy_left = 0; exp_stalls = 0; exp_redirs = 0;
    set_idle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    do_reset();

    // Load-use on rs=8: one hold cycle, then the bubble clears it.
    ex_is_load = 1'b1; ex_rf_wena = 1'b1; ex_rf_waddr = 5'd8;
    id_rs = 5'd8; id_uses_rs = 1'b1;
    cycle_check(sel);
    check("lu_hold", {30'd0, sel}, 32'd2);
    ex_is_load = 1'b0; ex_rf_wena = 1'b0; ex_rf_waddr = 5'd0;
    cycle_check(sel);
    check("lu_after_bubble", {30'd0, sel}, 32'd0);

    // Register zero never hazards.
    ex_is_load = 1'b1; ex_rf_wena = 1'b1; ex_rf_waddr = 5'd0; id_rs = 5'd0;
    cycle_check(sel);
    check("r0_no_stall", {30'd0, sel}, 32'd0);
    set_idle();

    // div issues, then mfhi waits for exactly MDU_LAT cycles.
    id_is_mdu = 1'b1;
    cycle_check(sel);
    id_is_mdu = 1'b0; id_reads_hilo = 1'b1;
    stalls = 0;
    for (int i = 0; i < MDU_LAT + 8; i++) begin
      cycle_check(sel);
      if (sel != 2'b10) break;
      stalls++;
    end
    check("mdu_stall_len", stalls, MDU_LAT);
    check("mfhi_proceeds", {30'd0, sel}, 32'd0);
    set_idle();

`ifdef PIPE_STALL_PERF_EN
    @(negedge clk);
    check("perf_stalls_33", stall_cycles, 32'd33);
    check("perf_redirs_0", redirect_cnt, 32'd0);
    @(posedge clk);
    #1;
`endif

    // addu flows freely while the MDU is busy.
    id_is_mdu = 1'b1;
    cycle_check(sel);
    id_is_mdu = 1'b0; id_uses_rs = 1'b1; id_uses_rt = 1'b1; id_rs = 5'd4; id_rt = 5'd5;
    for (int i = 0; i < 5; i++) begin
      cycle_check(sel);
      check("addu_free", {30'd0, sel}, 32'd0);
      check("addu_busy", {31'd0, mdu_busy}, 32'd1);
    end
    set_idle();
    for (int i = 0; i < MDU_LAT; i++) cycle_check(sel);

    // Stall beats redirect; redirect takes effect once hazard is gone.
    ex_is_load = 1'b1; ex_rf_wena = 1'b1; ex_rf_waddr = 5'd9;
    id_rt = 5'd9; id_uses_rt = 1'b1; id_redirect = 1'b1;
    cycle_check(sel);
    check("prio_hold", {30'd0, sel}, 32'd2);
    ex_is_load = 1'b0; ex_rf_wena = 1'b0;
    cycle_check(sel);
    check("prio_redirect", {30'd0, sel}, 32'd1);
    set_idle();

    // Reset in the middle of MDU busy, then mfhi is not stalled.
    id_is_mdu = 1'b1;
    cycle_check(sel);
    id_is_mdu = 1'b0;
    for (int i = 0; i < 10; i++) cycle_check(sel);
    do_reset();
    id_reads_hilo = 1'b1;
    cycle_check(sel);
    check("mfhi_after_rst", {30'd0, sel}, 32'd0);
    set_idle();

    // Random traffic with narrow register range to provoke matches.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 149) == 0) do_reset();
      id_rs         = 5'($urandom_range(0, 3));
      id_rt         = 5'($urandom_range(0, 3));
      ex_rf_waddr   = 5'($urandom_range(0, 3));
      id_uses_rs    = 1'($urandom_range(0, 1));
      id_uses_rt    = 1'($urandom_range(0, 1));
      ex_is_load    = 1'($urandom_range(0, 1));
      ex_rf_wena    = 1'($urandom_range(0, 3) != 0);
      id_redirect   = 1'($urandom_range(0, 3) == 0);
      id_is_mdu     = 1'($urandom_range(0, 7) == 0);
      id_reads_hilo = 1'($urandom_range(0, 5) == 0);
      cycle_check(sel);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got no end expected end");
    $fatal(1, "timeout");
  end

endmodule
